// File: rtl/mem_arbiter_if.sv
// Slot-arbiter bus bundle: slot strobe, three requesters, one-hot grants, slot phase and miss flag.
// master drives the strobe and requests and observes grants; slave is the arbiter side.
// Pure wiring; no state.
interface mem_arbiter_if;
  logic       clk_en;
  logic       video_req;
  logic       cpu_req;
  logic       dma_req;
  logic       video_gnt;
  logic       cpu_gnt;
  logic       dma_gnt;
  logic       refresh_gnt;
  logic [1:0] slot;
  logic       refresh_miss;

  modport master (
    output clk_en, video_req, cpu_req, dma_req,
    input  video_gnt, cpu_gnt, dma_gnt, refresh_gnt, slot, refresh_miss
  );

  modport slave (
    input  clk_en, video_req, cpu_req, dma_req,
    output video_gnt, cpu_gnt, dma_gnt, refresh_gnt, slot, refresh_miss
  );
endinterface

// File: rtl/mem_arbiter.sv
// Four-phase slot memory arbiter: even slots video > refresh > DMA, odd slots CPU > DMA, periodic refresh with sticky miss flag.
// Latency: grant for the next slot is registered on the clk_en edge that samples the requests; held for exactly one slot.
// Backpressure: requesters hold req until granted; nothing advances while clk_en=0. DMA participates only with MEM_ARBITER_DMA_EN defined.
module mem_arbiter #(
  parameter int REFRESH_PERIOD = 128
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [8:0] REFRESH_LAST = 9'(REFRESH_PERIOD - 1);

  logic [1:0] slot_q;
  logic [1:0] slot_next;
  logic [8:0] refresh_cnt_q;
  logic       refresh_pending_q;
  logic       refresh_miss_q;
  logic       refresh_wrap;

  logic       video_gnt_q;
  logic       cpu_gnt_q;
  logic       dma_gnt_q;
  logic       refresh_gnt_q;

  logic       dma_ok;
  logic       video_win;
  logic       cpu_win;
  logic       dma_win;
  logic       refresh_win;

`ifdef MEM_ARBITER_DMA_EN
  assign dma_ok = bus.dma_req;
`else
  // DMA is compiled out: its request is ignored and its grant can never be raised.
  logic dma_req_unused;
  assign dma_req_unused = bus.dma_req;
  assign dma_ok         = 1'b0;
`endif

  // Grants are decided against the slot we are about to enter, not the current one.
  assign slot_next    = slot_q + 2'd1;
  assign refresh_wrap = (refresh_cnt_q == REFRESH_LAST);

  // Fixed-priority pick for the upcoming slot; refresh and video are only eligible in even slots.
  always_comb begin
    video_win   = 1'b0;
    cpu_win     = 1'b0;
    dma_win     = 1'b0;
    refresh_win = 1'b0;
    if (!slot_next[0]) begin
      if (bus.video_req)          video_win   = 1'b1;
      else if (refresh_pending_q) refresh_win = 1'b1;
      else if (dma_ok)            dma_win     = 1'b1;
    end else begin
      if (bus.cpu_req)            cpu_win     = 1'b1;
      else if (dma_ok)            dma_win     = 1'b1;
    end
  end

  // Slot phase, registered grants and refresh bookkeeping; everything freezes between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q            <= 2'd0;
      video_gnt_q       <= 1'b0;
      cpu_gnt_q         <= 1'b0;
      dma_gnt_q         <= 1'b0;
      refresh_gnt_q     <= 1'b0;
      refresh_cnt_q     <= 9'd0;
      refresh_pending_q <= 1'b0;
      refresh_miss_q    <= 1'b0;
    end else if (bus.clk_en) begin
      slot_q        <= slot_next;
      video_gnt_q   <= video_win;
      cpu_gnt_q     <= cpu_win;
      dma_gnt_q     <= dma_win;
      refresh_gnt_q <= refresh_win;
      refresh_cnt_q <= refresh_wrap ? 9'd0 : refresh_cnt_q + 9'd1;
      if (refresh_wrap) begin
        // A new deadline arrives; if the previous one is still unserviced it was missed.
        // Pending stays a single flag, so a missed refresh is not queued twice.
        refresh_pending_q <= 1'b1;
        if (refresh_pending_q && !refresh_win) begin
          refresh_miss_q <= 1'b1;
        end
      end else if (refresh_win) begin
        refresh_pending_q <= 1'b0;
      end
    end
  end

  assign bus.slot         = slot_q;
  assign bus.video_gnt    = video_gnt_q;
  assign bus.cpu_gnt      = cpu_gnt_q;
  assign bus.dma_gnt      = dma_gnt_q;
  assign bus.refresh_gnt  = refresh_gnt_q;
  assign bus.refresh_miss = refresh_miss_q;

endmodule
